// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs and the stall/flush outputs.
// master = pipeline side (drives the hazard inputs), slave = controller side.
interface pipeline_hazard_ctrl_if;
  logic [3:0] src1;
  logic [3:0] src2;
  logic       two_src;
  logic [3:0] exe_dest;
  logic       exe_wb_en;
  logic       exe_mem_read;
  logic [3:0] mem_dest;
  logic       mem_wb_en;
  logic       branch_taken;
  logic       mem_req;
  logic       freeze_if;
  logic       freeze_id;
  logic       flush_id;
  logic       flush_exe;
  logic       freeze_all;
  logic       mem_busy;

  modport master (
    output src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, branch_taken, mem_req,
    input  freeze_if, freeze_id, flush_id, flush_exe, freeze_all, mem_busy
  );

  modport slave (
    input  src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, branch_taken, mem_req,
    output freeze_if, freeze_id, flush_id, flush_exe, freeze_all, mem_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Combinational RAW / branch handling plus a small FSM that freezes the whole
// pipeline for a fixed-latency data-memory access (MEM_LAT cycles in MEM).
// Optional feature macro: PIPE_FWD_EN (forwarding present -> only load-use stalls).
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT = 5
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Frozen cycles still owed after the first one (the IDLE cycle that sees
  // mem_req is itself frozen). Zero means the access goes straight to DONE.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 2);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       freeze_all_c;
  logic       mem_busy_c;
  logic       raw_c;
  logic       freeze_if_c, freeze_id_c, flush_id_c, flush_exe_c;

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory-access sequencing: cnt holds the frozen cycles remaining in WAIT,
  // including the current one, so WAIT lasts MEM_LAT-2 cycles.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    freeze_all_c = 1'b0;
    mem_busy_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hz.mem_req) begin
          freeze_all_c = 1'b1;
          if (CNT_LOAD == 4'd0) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        freeze_all_c = 1'b1;
        mem_busy_c   = 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        // The finished instruction is still in MEM: ignore its mem_req here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef PIPE_FWD_EN
  logic unused_mem_fields;
  assign unused_mem_fields = ^{hz.mem_dest, hz.mem_wb_en};

  // With forwarding, only a load feeding the very next instruction must stall.
  always_comb begin
    raw_c = hz.exe_mem_read && hz.exe_wb_en &&
            ((hz.src1 == hz.exe_dest) || (hz.two_src && (hz.src2 == hz.exe_dest)));
  end
`else
  logic unused_load_flag;
  assign unused_load_flag = hz.exe_mem_read;

  // Without forwarding, any pending write to a source register stalls.
  always_comb begin
    raw_c = (hz.exe_wb_en && (hz.src1 == hz.exe_dest)) ||
            (hz.mem_wb_en && (hz.src1 == hz.mem_dest)) ||
            (hz.two_src && hz.exe_wb_en && (hz.src2 == hz.exe_dest)) ||
            (hz.two_src && hz.mem_wb_en && (hz.src2 == hz.mem_dest));
  end
`endif

  // Output priority: memory freeze, then branch flush, then RAW stall.
  always_comb begin
    freeze_if_c = 1'b0;
    freeze_id_c = 1'b0;
    flush_id_c  = 1'b0;
    flush_exe_c = 1'b0;
    if (!rst) begin
      freeze_if_c = 1'b0;
    end else if (freeze_all_c) begin
      freeze_if_c = 1'b1;
      freeze_id_c = 1'b1;
    end else if (hz.branch_taken) begin
      // A hazard seen alongside a taken branch is on the wrong path.
      flush_id_c  = 1'b1;
      flush_exe_c = 1'b1;
    end else if (raw_c) begin
      freeze_if_c = 1'b1;
      freeze_id_c = 1'b1;
      flush_exe_c = 1'b1;
    end
  end

  assign hz.freeze_if  = freeze_if_c;
  assign hz.freeze_id  = freeze_id_c;
  assign hz.flush_id   = flush_id_c;
  assign hz.flush_exe  = flush_exe_c;
  assign hz.freeze_all = rst && freeze_all_c;
  assign hz.mem_busy   = rst && mem_busy_c;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios plus random stimulus,
// all checked against a cycle-count reference model of the controller.
module tb_pipeline_hazard_ctrl;
  localparam int MEM_LAT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  // Reference model state: cycles elapsed since the current memory access
  // started (0 = first frozen cycle), or -1 when no access is in progress.
  int ph       = -1;
  logic [5:0] obs, exp_v;

  function automatic logic ref_raw();
`ifdef PIPE_FWD_EN
    return hz.exe_mem_read && hz.exe_wb_en &&
           (hz.src1 == hz.exe_dest || (hz.two_src && hz.src2 == hz.exe_dest));
`else
    return (hz.exe_wb_en && hz.src1 == hz.exe_dest) ||
           (hz.mem_wb_en && hz.src1 == hz.mem_dest) ||
           (hz.two_src && hz.exe_wb_en && hz.src2 == hz.exe_dest) ||
           (hz.two_src && hz.mem_wb_en && hz.src2 == hz.mem_dest);
`endif
  endfunction

  function automatic int eff_phase();
    if (ph < 0 && hz.mem_req) return 0;
    return ph;
  endfunction

  // Expected {freeze_if, freeze_id, flush_id, flush_exe, freeze_all, mem_busy}.
  function automatic logic [5:0] ref_out();
    int p;
    logic fa, busy;
    if (!rst) return 6'b0;
    p    = eff_phase();
    fa   = (p >= 0) && (p <= MEM_LAT - 2);
    busy = (p >= 1) && (p <= MEM_LAT - 2);
    if (fa)               return {4'b1100, fa, busy};
    if (hz.branch_taken)  return {4'b0011, 1'b0, busy};
    if (ref_raw())        return {4'b1101, 1'b0, busy};
    return 6'b0;
  endfunction

  function automatic int ref_next();
    int p;
    if (!rst) return -1;
    p = eff_phase();
    if (p < 0) return -1;
    p = p + 1;
    if (p > MEM_LAT - 1) return -1;
    return p;
  endfunction

  task automatic quiet();
    rst = 1'b1;
    hz.src1 = 4'd0; hz.src2 = 4'd0; hz.two_src = 1'b0;
    hz.exe_dest = 4'd0; hz.exe_wb_en = 1'b0; hz.exe_mem_read = 1'b0;
    hz.mem_dest = 4'd0; hz.mem_wb_en = 1'b0;
    hz.branch_taken = 1'b0; hz.mem_req = 1'b0;
  endtask

  task automatic settle();
    #1;
    obs   = {hz.freeze_if, hz.freeze_id, hz.flush_id, hz.flush_exe, hz.freeze_all, hz.mem_busy};
    exp_v = ref_out();
  endtask

  task automatic tick();
    int nxt;
    nxt = ref_next();
    @(posedge clk);
    ph = nxt;
    cyc++;
    #1;
  endtask

  task automatic restart();
    quiet();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b0; hz.mem_req = 1'b1; hz.branch_taken = 1'b1;
    hz.src1 = 4'd3; hz.exe_dest = 4'd3; hz.exe_wb_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (obs !== 6'b0) $display("FAIL reset_hold cyc=%0d got=%b want=%b", cyc, obs, 6'b0);
      else n_pass++;
      tick();
    end
    quiet();
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if (obs !== 6'b0) $display("FAIL reset_release cyc=%0d got=%b want=%b", cyc, obs, 6'b0);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_mem_freeze();
    int fa_cnt = 0, busy_cnt = 0;
    logic fa_hist [MEM_LAT+1];
    restart();
    hz.mem_req = 1'b1;
    for (int i = 0; i <= MEM_LAT; i++) begin
      settle();
      n_checks++;
      if (obs !== exp_v) $display("FAIL mem_freeze cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      else n_pass++;
      fa_hist[i] = hz.freeze_all;
      if (i < MEM_LAT) begin
        fa_cnt   += int'(hz.freeze_all);
        busy_cnt += int'(hz.mem_busy);
      end
      tick();
    end
    n_checks++;
    if (fa_cnt !== MEM_LAT - 1) $display("FAIL freeze_len got=%0d want=%0d", fa_cnt, MEM_LAT - 1);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== MEM_LAT - 2) $display("FAIL busy_len got=%0d want=%0d", busy_cnt, MEM_LAT - 2);
    else n_pass++;
    n_checks++;
    if (fa_hist[MEM_LAT-1] !== 1'b0 || fa_hist[MEM_LAT] !== 1'b1)
      $display("FAIL done_then_retrigger got=%b%b want=01", fa_hist[MEM_LAT-1], fa_hist[MEM_LAT]);
    else n_pass++;
    hz.mem_req = 1'b0;
    for (int i = 0; i < MEM_LAT; i++) begin
      settle();
      n_checks++;
      if (obs !== exp_v) $display("FAIL mem_drain cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_branch_hazard();
    restart();
    hz.branch_taken = 1'b1; hz.src1 = 4'd3; hz.exe_dest = 4'd3; hz.exe_wb_en = 1'b1;
    settle();
    n_checks++;
    if (obs !== 6'b001100) $display("FAIL branch_over_raw got=%b want=%b", obs, 6'b001100);
    else n_pass++;
    n_checks++;
    if (obs !== exp_v) $display("FAIL branch_model got=%b want=%b", obs, exp_v);
    else n_pass++;
    tick();
  endtask

  task automatic test_raw();
    logic [5:0] want;
    restart();
    hz.src1 = 4'd1; hz.src2 = 4'd5; hz.two_src = 1'b1;
    hz.mem_dest = 4'd5; hz.mem_wb_en = 1'b1; hz.exe_dest = 4'd9; hz.exe_wb_en = 1'b1;
`ifdef PIPE_FWD_EN
    want = 6'b000000;
`else
    want = 6'b110100;
`endif
    settle();
    n_checks++;
    if (obs !== want) $display("FAIL raw_src2_mem got=%b want=%b", obs, want);
    else n_pass++;
    tick();
    hz.two_src = 1'b0;
    settle();
    n_checks++;
    if (obs !== 6'b0) $display("FAIL raw_two_src_gate got=%b want=%b", obs, 6'b0);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    restart();
    hz.exe_mem_read = 1'b1; hz.exe_wb_en = 1'b1; hz.exe_dest = 4'd2; hz.src1 = 4'd2;
    settle();
    n_checks++;
    if (obs !== 6'b110100) $display("FAIL load_use_stall got=%b want=%b", obs, 6'b110100);
    else n_pass++;
    tick();
    hz.exe_mem_read = 1'b0; hz.exe_wb_en = 1'b0; hz.exe_dest = 4'd0;
    hz.mem_dest = 4'd2; hz.mem_wb_en = 1'b1; hz.mem_req = 1'b1;
    settle();
    n_checks++;
    if (obs !== 6'b110010) $display("FAIL load_enter_freeze got=%b want=%b", obs, 6'b110010);
    else n_pass++;
    tick();
    for (int i = 1; i < MEM_LAT; i++) begin
      settle();
      n_checks++;
      if (obs !== exp_v) $display("FAIL load_access cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      else n_pass++;
      tick();
    end
    quiet();
    tick();
  endtask

  task automatic test_reset_mid_access();
    int fa_cnt = 0;
    restart();
    hz.mem_req = 1'b1;
    tick();
    settle();
    n_checks++;
    if (obs !== 6'b110011) $display("FAIL wait_busy got=%b want=%b", obs, 6'b110011);
    else n_pass++;
    tick();
    rst = 1'b0;
    settle();
    n_checks++;
    if (obs !== 6'b0) $display("FAIL mid_reset_outputs got=%b want=%b", obs, 6'b0);
    else n_pass++;
    tick();
    rst = 1'b1; hz.mem_req = 1'b0;
    settle();
    n_checks++;
    if (obs !== 6'b0) $display("FAIL after_mid_reset got=%b want=%b", obs, 6'b0);
    else n_pass++;
    tick();
    hz.mem_req = 1'b1;
    for (int i = 0; i < MEM_LAT; i++) begin
      settle();
      n_checks++;
      if (obs !== exp_v) $display("FAIL restart_access cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      else n_pass++;
      fa_cnt += int'(hz.freeze_all);
      tick();
    end
    n_checks++;
    if (fa_cnt !== MEM_LAT - 1) $display("FAIL restart_freeze_len got=%0d want=%0d", fa_cnt, MEM_LAT - 1);
    else n_pass++;
    quiet();
    for (int i = 0; i < MEM_LAT; i++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 24) != 0);
      hz.mem_req      = ($urandom_range(0, 3) == 0);
      hz.branch_taken = ($urandom_range(0, 4) == 0);
      hz.src1         = 4'($urandom_range(0, 3));
      hz.src2         = 4'($urandom_range(0, 3));
      hz.two_src      = 1'($urandom_range(0, 1));
      hz.exe_dest     = 4'($urandom_range(0, 3));
      hz.exe_wb_en    = 1'($urandom_range(0, 1));
      hz.exe_mem_read = 1'($urandom_range(0, 1));
      hz.mem_dest     = 4'($urandom_range(0, 3));
      hz.mem_wb_en    = 1'($urandom_range(0, 1));
      settle();
      n_checks++;
      if (obs !== exp_v) $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, exp_v);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    quiet();
    rst = 1'b0;
    test_reset();
    test_mem_freeze();
    test_branch_hazard();
    test_raw();
    test_load_use();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
